// File: rtl/ecd_proxy_pkg.sv
// Shared constants for the ECD AXI-proxy stream channel: packet field offsets,
// packet type, AXI mode/response encodings and the request arbiter state enum.
package ecd_proxy_pkg;

  localparam int unsigned AXIS_REQ_W  = 512;
  localparam int unsigned AXIS_RESP_W = 256;

  localparam int unsigned PKT_ADDR_LSB  = 0;
  localparam int unsigned PKT_DATA_LSB  = 32;
  localparam int unsigned PKT_MODE_BIT  = 64;
  localparam int unsigned PKT_TYPE_LSB  = 504;
  localparam int unsigned RESP_DATA_LSB = 32;
  localparam int unsigned RESP_CODE_LSB = 64;

  localparam logic [7:0] PKT_TYPE_AXI = 8'h01;

  localparam logic AXI_MODE_WRITE = 1'b0;
  localparam logic AXI_MODE_READ  = 1'b1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESPOND   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant,
// wrapping at N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic          found;
  logic [31:0]   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(last_grant_i) + k) % N;
      cand_idx = IW'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ecd_request_arbiter.sv
// Shares the ECD AXI-proxy stream channel among NUM_REQ requesters: round-robin
// grant, request packet build, single outstanding transaction, response timeout.
module ecd_request_arbiter
  import ecd_proxy_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [NUM_REQ*32-1:0]    req_data,
  input  logic [NUM_REQ-1:0]       req_mode,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [31:0]              resp_data,
  output logic [1:0]               resp_code,
  output logic [AXIS_REQ_W-1:0]    AXIS_OUT_LO_TDATA,
  output logic                     AXIS_OUT_LO_TVALID,
  output logic                     AXIS_OUT_LO_TLAST,
  input  logic                     AXIS_OUT_LO_TREADY,
  output logic [AXIS_REQ_W-1:0]    AXIS_OUT_HI_TDATA,
  output logic                     AXIS_OUT_HI_TVALID,
  output logic                     AXIS_OUT_HI_TLAST,
  input  logic                     AXIS_OUT_HI_TREADY,
  input  logic [AXIS_RESP_W-1:0]   AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  output logic                     AXIS_IN_TREADY,
  output logic [15:0]              timeout_count,
  output logic [15:0]              stale_count
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state_q;
  logic [IW-1:0]        last_grant_q;
  logic [31:0]          addr_q, data_q;
  logic                 mode_q;
  logic                 lo_valid_q, hi_valid_q;
  logic                 lo_valid_d, hi_valid_d;
  logic [31:0]          timer_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [31:0]          resp_data_q;
  logic [1:0]           resp_code_q;
  logic [15:0]          timeout_cnt_q, stale_cnt_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic [31:0]          addr_sel, data_sel;
  logic                 tmo_hit;
  logic [31:0]          in_data;
  logic [1:0]           in_code;
  logic                 unused_in_bits;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx)
  );

  assign addr_sel = req_addr[{arb_idx, 5'b0} +: 32];
  assign data_sel = req_data[{arb_idx, 5'b0} +: 32];
  assign in_data  = AXIS_IN_TDATA[RESP_DATA_LSB +: 32];
  assign in_code  = AXIS_IN_TDATA[RESP_CODE_LSB +: 2];
  assign unused_in_bits = ^{AXIS_IN_TDATA[AXIS_RESP_W-1:RESP_CODE_LSB+2],
                            AXIS_IN_TDATA[RESP_DATA_LSB-1:0]};

  // Terminal count of the response wait; a zero limit never expires.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (timer_q == 32'(TIMEOUT_CYCLES - 1));

  assign lo_valid_d = lo_valid_q & ~AXIS_OUT_LO_TREADY;
  assign hi_valid_d = hi_valid_q & ~AXIS_OUT_HI_TREADY;

  // Grant strobe and IN ready stay low while reset is held.
  assign req_ready      = (resetn && state_q == ST_IDLE) ? arb_grant : '0;
  assign AXIS_IN_TREADY = resetn && (state_q == ST_IDLE || state_q == ST_WAIT_RESP);

  always_comb begin
    AXIS_OUT_LO_TDATA                              = '0;
    AXIS_OUT_LO_TDATA[PKT_ADDR_LSB +: 32]          = addr_q;
    AXIS_OUT_LO_TDATA[PKT_DATA_LSB +: 32]          = data_q;
    AXIS_OUT_LO_TDATA[PKT_MODE_BIT]                = mode_q;
    AXIS_OUT_LO_TDATA[PKT_TYPE_LSB +: 8]           = PKT_TYPE_AXI;
  end

  assign AXIS_OUT_HI_TDATA  = '0;
  assign AXIS_OUT_LO_TLAST  = 1'b1;
  assign AXIS_OUT_HI_TLAST  = 1'b1;
  assign AXIS_OUT_LO_TVALID = lo_valid_q;
  assign AXIS_OUT_HI_TVALID = hi_valid_q;
  assign resp_valid         = resp_valid_q;
  assign resp_data          = resp_data_q;
  assign resp_code          = resp_code_q;
  assign timeout_count      = timeout_cnt_q;
  assign stale_count        = stale_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= IW'(NUM_REQ - 1);
      addr_q        <= '0;
      data_q        <= '0;
      mode_q        <= 1'b0;
      lo_valid_q    <= 1'b0;
      hi_valid_q    <= 1'b0;
      timer_q       <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      resp_code_q   <= AXI_RESP_OKAY;
      timeout_cnt_q <= '0;
      stale_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (AXIS_IN_TVALID && stale_cnt_q != 16'hFFFF) begin
            stale_cnt_q <= stale_cnt_q + 16'd1;
          end
          if (|req_valid) begin
            last_grant_q <= arb_idx;
            addr_q       <= addr_sel;
            data_q       <= data_sel;
            mode_q       <= req_mode[arb_idx];
            lo_valid_q   <= 1'b1;
            hi_valid_q   <= 1'b1;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          lo_valid_q <= lo_valid_d;
          hi_valid_q <= hi_valid_d;
          if (!lo_valid_d && !hi_valid_d) begin
            timer_q <= '0;
            state_q <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          // A response in the terminal-count cycle takes priority over the timeout.
          if (AXIS_IN_TVALID) begin
            resp_data_q  <= (mode_q == AXI_MODE_READ) ? in_data : 32'h0;
            resp_code_q  <= in_code;
            resp_valid_q <= NUM_REQ'(1) << last_grant_q;
            state_q      <= ST_RESPOND;
          end else if (tmo_hit) begin
            resp_data_q  <= 32'h0;
            resp_code_q  <= AXI_RESP_SLVERR;
            resp_valid_q <= NUM_REQ'(1) << last_grant_q;
            if (timeout_cnt_q != 16'hFFFF) begin
              timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
            state_q      <= ST_RESPOND;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        ST_RESPOND: begin
          resp_valid_q <= '0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ecd_request_arbiter.md
# ecd_request_arbiter

Shares the single ECD AXI-proxy stream channel (512-bit LO/HI request streams plus 256-bit response stream) among NUM_REQ internal requesters, such as the host AXI4-Lite proxy, the preload-complete notifier and status pollers. It grants one requester at a time using round-robin arbitration and builds the request packet. It keeps exactly one transaction outstanding, returns the response to the granting requester, and times out lost responses. It sits between the requesters and the ECD link stream FIFOs.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- TIMEOUT_CYCLES, 1_000_000: response wait limit in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- req_addr  in  NUM_REQ*32  slice i is the AXI address for requester i.
- req_data  in  NUM_REQ*32  slice i is the write data for requester i.
- req_mode  in  NUM_REQ  per-requester mode: 0 = write, 1 = read.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_data  out  32  read data; shared by all requesters.
- resp_code  out  2  AXI response code (OKAY 0, SLVERR 2, DECERR 3).
- AXIS_OUT_LO_TDATA/TVALID/TLAST/TREADY  512-bit request stream, lo half.
- AXIS_OUT_HI_TDATA/TVALID/TLAST/TREADY  512-bit request stream, hi half.
- AXIS_IN_TDATA/TVALID/TREADY  256-bit response stream.
- timeout_count  out  16  saturating count of timed-out transactions.
- stale_count  out  16  saturating count of response packets discarded outside WAIT_RESP.

## Operation
- Request packet layout:
  - LO[31:0] = address, LO[63:32] = data, LO[64] = mode, LO[511:504] = 8'h01.
  - All other LO bits are 0. HI TDATA is all 0.
  - Both TLASTs are tied to 1.
- Response fields:
  - IN[31:0] = address (ignored).
  - IN[63:32] = data.
  - IN[65:64] = response code. Bit 66 is ignored.
- State IDLE:
  - If any req_valid bit is set, the round-robin grant picks the first set bit searching upward from last_grant+1, wrapping at NUM_REQ.
  - req_ready[g] is asserted combinationally that cycle.
  - On the clock edge the block latches addr/data/mode/g, updates last_grant to g, raises both OUT TVALIDs and moves to SEND.
  - AXIS_IN_TREADY = 1 in IDLE. Any arriving packet is discarded and stale_count increments.
- State SEND:
  - Each TVALID drops on its own handshake.
  - When both TVALIDs are 0, the block clears the timer and moves to WAIT_RESP.
  - AXIS_IN_TREADY = 0.
- State WAIT_RESP:
  - AXIS_IN_TREADY = 1.
  - On IN handshake: latch resp_data (reads only; writes return 0) and resp_code, then move to RESPOND.
  - If the timer reaches TIMEOUT_CYCLES-1 without a handshake: resp_data = 0, resp_code = SLVERR, timeout_count++, move to RESPOND.
- State RESPOND: pulse resp_valid[g] for one cycle, then return to IDLE.
- Requesters must hold req_valid/addr/data/mode stable until req_ready. resp_valid has no backpressure.

## Timing
- Reset values:
  - All TVALIDs = 0. AXIS_IN_TREADY = 0 during reset and 1 in the first IDLE cycle after it.
  - req_ready = 0, resp_valid = 0, resp_data = 0, resp_code = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Counters = 0, state = IDLE.
- Latency with both TREADYs high and an immediate response: req_ready at cycle 0, TVALIDs at cycle 1, WAIT_RESP at cycle 2, response handshake at cycle 2 at the earliest, resp_valid at cycle 3.
- Minimum issue interval is 4 cycles per transaction. A requester may re-request the cycle after its resp_valid.
- Simultaneous requests are granted strictly by rotation. No requester waits more than NUM_REQ-1 grants.
- A response that arrives during the same cycle as the timeout terminal count wins: it is accepted and there is no timeout.
- A late response after a timeout arrives in IDLE and is counted as stale.
- Reset asserted mid-transaction aborts the transaction and issues no resp_valid.
- timeout_count and stale_count saturate at 16'hFFFF.

## Structure
- Package ecd_proxy_pkg holds:
  - Packet field offsets.
  - PKT_TYPE_AXI = 8'h01.
  - AXI_MODE_WRITE/READ.
  - Response codes OKAY/SLVERR/DECERR.
  - The state enum.
- Sub-module rr_arbiter (parameter N) is combinational: inputs req and last_grant, outputs a one-hot grant and its index.

## Test plan
- Single write: requester 1 sends addr 0x1000, data 0xF; response code 0 -> LO TDATA[64:0] = {0, 0xF, 0x1000}, [511:504] = 1; resp_valid[1] with resp_code 0.
- Read: requester 2 reads 0x20, response data 0x12345678, code 0 -> resp_data 0x12345678 on resp_valid[2].
- All 4 requesters hold req_valid -> grant order 0,1,2,3,0. HI TREADY delayed 5 cycles -> LO TVALID drops first, WAIT_RESP entered only after the HI handshake.
- TIMEOUT_CYCLES = 16, no response -> resp_code 2 and resp_data 0 at cycle 16 of WAIT_RESP, timeout_count = 1. A later response is discarded and stale_count = 1.
- Reset asserted in WAIT_RESP -> all outputs at reset values next cycle, no resp_valid. A new request then completes normally.
